// File: rtl/menu_nav_ctrl_if.sv
// Key-pulse inputs and menu-state outputs of the front-panel menu controller.
// Widths follow the controller's page/field/value parameters.
interface menu_nav_ctrl_if #(
    parameter int N_PAGES  = 3,
    parameter int N_FIELDS = 5,
    parameter int VAL_W    = 2
);
    localparam int PG_W = (N_PAGES  > 1) ? $clog2(N_PAGES)  : 1;
    localparam int FD_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

    logic                          key_left;
    logic                          key_right;
    logic                          key_up;
    logic                          key_down;
    logic                          key_confirm;
    logic                          key_quit;
    logic [PG_W-1:0]               page_sel;
    logic                          level;
    logic [FD_W-1:0]               field_sel;
    logic [(N_FIELDS-1)*VAL_W-1:0] field_vals;
    logic                          applied;
    logic                          apply_pulse;

    modport master (
        output key_left, key_right, key_up, key_down, key_confirm, key_quit,
        input  page_sel, level, field_sel, field_vals, applied, apply_pulse
    );

    modport slave (
        input  key_left, key_right, key_up, key_down, key_confirm, key_quit,
        output page_sel, level, field_sel, field_vals, applied, apply_pulse
    );
endinterface

// File: rtl/menu_nav_ctrl.sv
// Two-level front-panel menu: page select -> field edit -> apply, with an
// independent value bank per page.
module menu_nav_ctrl #(
    parameter int N_PAGES      = 3,
    parameter int N_FIELDS     = 5,
    parameter int VAL_W        = 2,
    parameter int VAL_MAX      = 3,
    parameter int KEEP_ON_QUIT = 0
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    menu_nav_ctrl_if.slave   bus
);
    localparam int PG_W = (N_PAGES  > 1) ? $clog2(N_PAGES)  : 1;
    localparam int FD_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int NV   = N_FIELDS - 1;

    typedef enum logic [1:0] {S_TOP, S_EDIT, S_APPLIED} state_t;
    typedef logic [VAL_W-1:0] val_t;

    state_t          state_q, state_d;
    logic [PG_W-1:0] page_q, page_d;
    logic [FD_W-1:0] field_q, field_d;
    logic            pulse_q, pulse_d;
    val_t            bank_q [N_PAGES][NV];
    val_t            bank_d [N_PAGES][NV];

    logic            quit_act, conf_act, ud_act, lr_act, on_apply;
    val_t            cur_val, new_val;
    logic [NV*VAL_W-1:0] vals;

    // Only the highest-priority key class acts; a held up/down pair still masks left/right.
    assign quit_act = bus.key_quit;
    assign conf_act = !bus.key_quit && bus.key_confirm;
    assign ud_act   = !bus.key_quit && !bus.key_confirm && (bus.key_up ^ bus.key_down);
    assign lr_act   = !bus.key_quit && !bus.key_confirm && !bus.key_up && !bus.key_down
                      && (bus.key_left ^ bus.key_right);
    assign on_apply = (field_q == FD_W'(NV));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_TOP;
            page_q  <= '0;
            field_q <= '0;
            pulse_q <= 1'b0;
            for (int unsigned p = 0; p < N_PAGES; p++)
                for (int unsigned k = 0; k < NV; k++)
                    bank_q[p][k] <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            field_q <= field_d;
            pulse_q <= pulse_d;
            bank_q  <= bank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        field_d = field_q;
        pulse_d = 1'b0;
        bank_d  = bank_q;
        cur_val = '0;
        new_val = '0;
        if (!on_apply)
            cur_val = bank_q[page_q][field_q];
        if (bus.key_left)
            new_val = (cur_val == '0) ? val_t'(VAL_MAX) : cur_val - 1'b1;
        else
            new_val = (cur_val == val_t'(VAL_MAX)) ? '0 : cur_val + 1'b1;

        case (state_q)
            S_TOP: begin
                if (conf_act) begin
                    state_d = S_EDIT;
                    field_d = '0;
                end else if (lr_act) begin
                    if (bus.key_left)
                        page_d = (page_q == '0) ? PG_W'(N_PAGES - 1) : page_q - 1'b1;
                    else
                        page_d = (page_q == PG_W'(N_PAGES - 1)) ? '0 : page_q + 1'b1;
                end
            end
            default: begin
                if (quit_act) begin
                    state_d = S_TOP;
                    field_d = '0;
                    if (KEEP_ON_QUIT == 0)
                        for (int unsigned k = 0; k < NV; k++)
                            bank_d[page_q][k] = '0;
                end else if (conf_act) begin
                    if (on_apply) begin
                        state_d = S_APPLIED;
                        pulse_d = 1'b1;
                    end
                end else if (ud_act) begin
                    if (bus.key_up)
                        field_d = (field_q == '0) ? FD_W'(NV) : field_q - 1'b1;
                    else
                        field_d = on_apply ? '0 : field_q + 1'b1;
                end else if (lr_act && !on_apply) begin
                    bank_d[page_q][field_q] = new_val;
                    pulse_d = (state_q == S_APPLIED) && (new_val != cur_val);
                end
            end
        endcase
    end

    always_comb begin
        vals = '0;
        for (int unsigned k = 0; k < NV; k++)
            vals[k*VAL_W +: VAL_W] = bank_q[page_q][k];
    end

    assign bus.page_sel    = page_q;
    assign bus.level       = (state_q != S_TOP);
    assign bus.field_sel   = field_q;
    assign bus.field_vals  = vals;
    assign bus.applied     = (state_q == S_APPLIED);
    assign bus.apply_pulse = pulse_q;
endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Directed vector bench for menu_nav_ctrl (default parameters, bank cleared on quit).
module tb_menu_nav_ctrl;
    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    always #10 clk_50M = ~clk_50M;

    menu_nav_ctrl_if #(.N_PAGES(3), .N_FIELDS(5), .VAL_W(2)) bus ();

    menu_nav_ctrl #(
        .N_PAGES(3), .N_FIELDS(5), .VAL_W(2), .VAL_MAX(3), .KEEP_ON_QUIT(0)
    ) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // keys = {quit, confirm, up, down, left, right}
    localparam logic [5:0] K_0 = 6'b000000, K_R = 6'b000001, K_L = 6'b000010,
                           K_D = 6'b000100, K_U = 6'b001000, K_C = 6'b010000,
                           K_Q = 6'b100000;

    typedef struct {
        logic [5:0]  keys;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // expected = {page_sel[1:0], level, field_sel[2:0], field_vals[7:0], applied, apply_pulse}
    function automatic logic [15:0] pk(input int pg, input int lv, input int fd,
                                       input int vl, input int ap, input int pu);
        pk = {pg[1:0], lv[0], fd[2:0], vl[7:0], ap[0], pu[0]};
    endfunction

    function automatic logic [15:0] got();
        got = {bus.page_sel, bus.level, bus.field_sel, bus.field_vals, bus.applied, bus.apply_pulse};
    endfunction

    task automatic check(input string name, input logic [15:0] exp);
        logic [15:0] g;
        g = got();
        n_cmp++;
        if (g !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, g, exp);
        end
    endtask

    task automatic drive(input logic [5:0] k);
        {bus.key_quit, bus.key_confirm, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = k;
    endtask

    // Called at a negedge: pulse keys for one cycle, return #1 after the capturing edge.
    task automatic press(input logic [5:0] k);
        drive(k);
        @(posedge clk_50M);
        #1;
        drive(K_0);
    endtask

    task automatic add(input logic [5:0] k, input logic [15:0] e);
        vec_t v;
        v.keys = k;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    initial begin
        add(K_R, pk(1,0,0,8'h00,0,0));
        add(K_R, pk(2,0,0,8'h00,0,0));
        add(K_R, pk(0,0,0,8'h00,0,0));
        add(K_C, pk(0,1,0,8'h00,0,0));
        add(K_R, pk(0,1,0,8'h01,0,0));
        add(K_R, pk(0,1,0,8'h02,0,0));
        add(K_R, pk(0,1,0,8'h03,0,0));
        add(K_R, pk(0,1,0,8'h00,0,0));
        add(K_L, pk(0,1,0,8'h03,0,0));
        add(K_U, pk(0,1,4,8'h03,0,0));
        add(K_R, pk(0,1,4,8'h03,0,0));
        add(K_C, pk(0,1,4,8'h03,1,1));
        add(K_0, pk(0,1,4,8'h03,1,0));
        add(K_C, pk(0,1,4,8'h03,1,1));
        add(K_0, pk(0,1,4,8'h03,1,0));
        add(K_D, pk(0,1,0,8'h03,1,0));
        add(K_D, pk(0,1,1,8'h03,1,0));
        add(K_R, pk(0,1,1,8'h07,1,1));
        add(K_0, pk(0,1,1,8'h07,1,0));
        add(K_L, pk(0,1,1,8'h03,1,1));
        add(K_Q, pk(0,0,0,8'h00,0,0));
        add(K_C, pk(0,1,0,8'h00,0,0));
        add(K_Q | K_C | K_R, pk(0,0,0,8'h00,0,0));
        add(K_L, pk(2,0,0,8'h00,0,0));
        add(K_C, pk(2,1,0,8'h00,0,0));
        add(K_D, pk(2,1,1,8'h00,0,0));
        add(K_R, pk(2,1,1,8'h04,0,0));
        add(K_R, pk(2,1,1,8'h08,0,0));
        add(K_L | K_R, pk(2,1,1,8'h08,0,0));
        add(K_U | K_D, pk(2,1,1,8'h08,0,0));
        add(K_C, pk(2,1,1,8'h08,0,0));

        drive(K_0);
        #5;
        check("reset_state", pk(0,0,0,8'h00,0,0));
        @(negedge clk_50M);
        rst_n = 1'b1;
        @(negedge clk_50M);

        foreach (tbl[i]) begin
            press(tbl[i].keys);
            check($sformatf("vec%0d", i), tbl[i].exp);
            @(negedge clk_50M);
        end

        // Async reset mid-edit on page 2: outputs clear with no clock edge.
        #2 rst_n = 1'b0;
        #1 check("async_rst_edit", pk(0,0,0,8'h00,0,0));
        @(negedge clk_50M);
        rst_n = 1'b1;
        @(negedge clk_50M);
        press(K_C);
        check("reenter_page0", pk(0,1,0,8'h00,0,0));
        @(negedge clk_50M);

        // Async reset while apply_pulse is high.
        press(K_U);
        @(negedge clk_50M);
        press(K_C);
        check("pulse_before_rst", pk(0,1,4,8'h00,1,1));
        rst_n = 1'b0;
        #1 check("pulse_async_clear", pk(0,0,0,8'h00,0,0));
        @(negedge clk_50M);
        rst_n = 1'b1;
        @(negedge clk_50M);

        // Left/right on APPLY field changes nothing; bank of page 1 previews at top.
        press(K_R);
        check("top_page1", pk(1,0,0,8'h00,0,0));
        @(negedge clk_50M);
        press(K_C);
        @(negedge clk_50M);
        press(K_L);
        check("p1_f0_wrap_down", pk(1,1,0,8'h03,0,0));
        @(negedge clk_50M);
        press(K_U);
        @(negedge clk_50M);
        press(K_L);
        check("apply_field_lr", pk(1,1,4,8'h03,0,0));
        @(negedge clk_50M);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
